uart_rx_fifo_core: RTL and testbench
====================================

# uart_rx_fifo_core

Parametrised UART receive core: 2-FF synchroniser, oversampled bit timing with 3-sample majority vote, configurable data width, parity and stop bits, and a small receive FIFO with a valid/ready output stream. Sits between the board `uart_rx` pin and any byte consumer (command parser, debug bridge). Supersedes the fixed 8N1, centre-sample-only receiver.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency, Hz
- `BAUD_RATE`, 115200: line rate, baud
- `OVERSAMPLE`, 16: ticks per bit; even, 8..32
- `DATA_BITS`, 8: payload bits per frame; 5..9
- `PARITY`, 0: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1: 1 or 2
- `FIFO_DEPTH`, 4: receive FIFO entries; power of 2, ≥2
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `uart_rx` in 1: asynchronous serial input, idle high
- `m_data` out DATA_BITS: FIFO head entry (show-ahead)
- `m_valid` out 1: FIFO non-empty
- `m_ready` in 1: consumer accepts head when `m_valid` high
- `frame_err` out 1: one-cycle pulse, stop bit sampled low
- `parity_err` out 1: one-cycle pulse, parity mismatch
- `overrun` out 1: one-cycle pulse, good frame dropped because FIFO full

## Operation
- Reset: all outputs 0; sync flops 1; state IDLE; FIFO empty; dividers 0. Reset mid-frame abandons the frame and flushes the FIFO.
- Tick divider: `DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE)` (integer divide, must be ≥1); counter 0..DIV-1, tick when counter == DIV-1, wraps to 0.
- Per bit, sample index `s` counts 0..OVERSAMPLE-1 on ticks. With `M = OVERSAMPLE/2`, samples at `s` = M-1, M, M+1; bit value = majority of the three.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: synchronised line 0 → START; tick counter and `s` cleared that cycle.
  - START: majority 0 → DATA at end of bit (`s` == OVERSAMPLE-1); majority 1 → IDLE at `s` == M+1 (false start, no pulse).
  - DATA: DATA_BITS bits, LSB first; advance at end of each bit.
  - PARITY (PARITY≠0 only): odd → data XOR parity must be 1; even → must be 0.
  - STOP: decided at `s` == M+1 of the last stop bit; with STOP_BITS=2 the first stop bit is also checked at its own `s` == M+1 and runs full length. Any stop sample 0 → `frame_err`. Return to IDLE at that point (half-bit early) for resynchronisation.
- Frame outcome: frame error takes priority; a frame with frame or parity error is discarded (pulse only, one pulse per frame). Good frame: push if FIFO not full; if full and no pop that same cycle, drop and pulse `overrun`.
- FIFO: pop when `m_valid && m_ready`. Simultaneous push and pop when full: both occur, no overrun. Push and pop when empty: push only (no bypass).

## Timing
- Input latency: 2 `clk` through synchroniser.
- Push happens on the cycle STOP decides; `m_valid` rises the following cycle, with `m_data` valid.
- Error and overrun pulses are asserted the cycle after the STOP decision, exactly one cycle wide.
- `m_data` holds the head entry; its value when `m_valid`=0 is unspecified (0 after reset).
- Pop takes effect at the clock edge; next head appears the following cycle.

## Configuration
- `UART_RX_DISPLAY_EN` defined: simulation-only `$display("Received byte: 0x%h", data)` on every push, and `"UART RX frame error"` / `"UART RX parity error"` / `"UART RX overrun"` on each pulse.
- Not defined: no display statements compiled; synthesisable logic identical.

## Structure
- Package `uart_pkg`: `uart_parity_t` enum (NONE, ODD, EVEN), `uart_rx_state_t` enum (IDLE, START, DATA, PARITY, STOP), divider helper function.
- Sub-module `uart_rx_fifo`: synchronous FIFO, parameters WIDTH/DEPTH, ports push/din/full, pop/dout/empty, show-ahead, `rst` flushes.
- Parameter legality checked with elaboration-time assertions.

## Test plan
Bench runs CLK_FREQ=1_600_000, BAUD_RATE=100_000, OVERSAMPLE=16 (DIV=1).
- 8N1, send 0xA5, 0x3C, m_ready=1 -> two handshakes, data 0xA5 then 0x3C, no error pulses.
- PARITY=2, DATA_BITS=7, send 0x41 with wrong parity bit -> `parity_err` one pulse, `m_valid` stays 0.
- Stop bit driven low for frame 0x55 -> `frame_err` pulse, nothing pushed; next frame 0x12 received correctly.
- FIFO_DEPTH=4, m_ready=0, send 5 frames 0x01..0x05 -> 4 entries held, `overrun` pulse on 5th; drain yields 0x01..0x04.
- 1-tick glitch low in idle and single corrupted sample mid-data-bit -> no false start; majority vote yields correct byte 0xF0.
- `rst` asserted mid-frame with 2 bytes queued -> all outputs 0 next cycle, FIFO empty, subsequent 0x7E received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive core.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } uart_parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_t;

    // Clock cycles per oversampling tick.
    function automatic int uart_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO; the head entry is held in a register so the
// storage array is only ever read through a clocked port.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_inc;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             wr_en;
    logic             rd_en;

    assign full       = (count_reg == (AW+1)'(DEPTH));
    assign empty      = (count_reg == '0);
    assign rd_en      = pop && !empty;
    assign wr_en      = push && (!full || rd_en);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign dout       = dout_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Head register: a write into an empty FIFO, or a pop that
            // exposes the next entry (or the entry being written now).
            if (empty && wr_en) begin
                dout_reg <= din;
            end else if (rd_en) begin
                dout_reg <= (count_reg == (AW+1)'(1)) ? din : mem[rd_ptr_inc];
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo_core.sv
// Oversampled UART receiver with 3-sample majority vote and a receive FIFO.
// Define UART_RX_DISPLAY_EN to print received bytes and error events in simulation.
module uart_rx_fifo_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [SW-1:0] S_FIRST   = SW'(M - 1);
    localparam logic [SW-1:0] S_MID     = SW'(M);
    localparam logic [SW-1:0] S_LAST    = SW'(M + 1);
    localparam logic [SW-1:0] S_END     = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam uart_parity_t  PAR_MODE  = (PARITY == 1) ? PAR_ODD :
                                          (PARITY == 2) ? PAR_EVEN : PAR_NONE;

    if (DIV < 1) begin : g_chk_div
        $error("CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
        $error("OVERSAMPLE must be even and within 8..32");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
        $error("DATA_BITS must be within 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    uart_rx_state_t       state_reg, state_next;
    logic                 sync1_reg, sync2_reg;
    logic [DW-1:0]        div_cnt_reg, div_cnt_next;
    logic [SW-1:0]        s_reg, s_next;
    logic [1:0]           samp_reg, samp_next;
    logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic                 stop_bad_reg, stop_bad_next;
    logic                 par_bit_reg, par_bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 frame_err_reg, parity_err_reg, overrun_reg;

    logic tick, maj, at_last, at_end;
    logic decide, frame_bad, par_bad, good;
    logic push, pop, fifo_full, fifo_empty;
    logic rx_s;

    assign rx_s    = sync2_reg;
    assign tick    = (div_cnt_reg == DIV_LAST);
    assign maj     = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
    assign at_last = tick && (s_reg == S_LAST);
    assign at_end  = tick && (s_reg == S_END);

    always_comb begin
        par_bad = 1'b0;
        unique case (PAR_MODE)
            PAR_ODD:  par_bad = ~(^shift_reg ^ par_bit_reg);
            PAR_EVEN: par_bad = ^shift_reg ^ par_bit_reg;
            default:  par_bad = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = tick ? '0 : div_cnt_reg + 1'b1;
        s_next        = s_reg;
        samp_next     = samp_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        stop_bad_next = stop_bad_reg;
        par_bit_next  = par_bit_reg;
        shift_next    = shift_reg;
        decide        = 1'b0;
        frame_bad     = 1'b0;

        if (tick) begin
            s_next = (s_reg == S_END) ? '0 : s_reg + 1'b1;
            if (s_reg == S_FIRST) samp_next[0] = rx_s;
            if (s_reg == S_MID)   samp_next[1] = rx_s;
        end

        unique case (state_reg)
            ST_IDLE: begin
                // Timing restarts from the detected falling edge.
                div_cnt_next = '0;
                s_next       = '0;
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (at_last && maj) begin
                    state_next = ST_IDLE;
                end else if (at_end) begin
                    state_next    = ST_DATA;
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                    stop_bad_next = 1'b0;
                end
            end
            ST_DATA: begin
                if (at_last) begin
                    shift_next = {maj, shift_reg[DATA_BITS-1:1]};
                end
                if (at_end) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_last) begin
                    par_bit_next = maj;
                end
                if (at_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // The last stop bit ends the frame at its sample point.
                if (at_last) begin
                    if (stop_cnt_reg == STOP_LAST) begin
                        decide     = 1'b1;
                        frame_bad  = stop_bad_reg | ~maj;
                        state_next = ST_IDLE;
                    end else begin
                        stop_bad_next = stop_bad_reg | ~maj;
                    end
                end else if (at_end) begin
                    stop_cnt_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign good = decide && !frame_bad && !par_bad;
    assign pop  = m_valid && m_ready;
    assign push = good && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            sync1_reg      <= 1'b1;
            sync2_reg      <= 1'b1;
            div_cnt_reg    <= '0;
            s_reg          <= '0;
            samp_reg       <= '0;
            bit_cnt_reg    <= '0;
            stop_cnt_reg   <= 1'b0;
            stop_bad_reg   <= 1'b0;
            par_bit_reg    <= 1'b0;
            shift_reg      <= '0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sync1_reg      <= uart_rx;
            sync2_reg      <= sync1_reg;
            div_cnt_reg    <= div_cnt_next;
            s_reg          <= s_next;
            samp_reg       <= samp_next;
            bit_cnt_reg    <= bit_cnt_next;
            stop_cnt_reg   <= stop_cnt_next;
            stop_bad_reg   <= stop_bad_next;
            par_bit_reg    <= par_bit_next;
            shift_reg      <= shift_next;
            frame_err_reg  <= decide && frame_bad;
            parity_err_reg <= decide && !frame_bad && par_bad;
            overrun_reg    <= good && fifo_full && !pop;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shift_reg),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (m_data),
        .empty (fifo_empty)
    );

    assign m_valid    = !fifo_empty;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = overrun_reg;

`ifdef UART_RX_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push)           $display("Received byte: 0x%h", shift_reg);
            if (frame_err_reg)  $display("UART RX frame error");
            if (parity_err_reg) $display("UART RX parity error");
            if (overrun_reg)    $display("UART RX overrun");
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// Directed bench: an 8N1 receiver (depth 4) and a 7E1 receiver, DIV=1, 16 clk per bit.
`timescale 1ns/1ps
module tb_uart_rx_fifo_core;

    localparam int BIT_CYC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       m_ready_a = 1'b0;
    logic       m_ready_b = 1'b0;
    logic [7:0] m_data_a;
    logic [6:0] m_data_b;
    logic       m_valid_a, m_valid_b;
    logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0] got_a [64];
    logic [6:0] got_b [16];
    int got_n_a  = 0;
    int got_n_b  = 0;
    int fe_cnt_a = 0;
    int pe_cnt_a = 0;
    int ov_cnt_a = 0;
    int fe_cnt_b = 0;
    int pe_cnt_b = 0;
    int vcyc_b   = 0;

    uart_rx_fifo_core #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .uart_rx(rx_a),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
    );

    uart_rx_fifo_core #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .uart_rx(rx_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
    );

    // Handshake and pulse monitor; inputs change at posedge+2, so negedge is stable.
    always @(negedge clk) begin
        if (m_valid_a && m_ready_a) begin
            got_a[got_n_a[5:0]] <= m_data_a;
            got_n_a <= got_n_a + 1;
            $display("A pop 0x%02h", m_data_a);
        end
        if (m_valid_b && m_ready_b) begin
            got_b[got_n_b[3:0]] <= m_data_b;
            got_n_b <= got_n_b + 1;
            $display("B pop 0x%02h", m_data_b);
        end
        fe_cnt_a <= fe_cnt_a + int'(fe_a);
        pe_cnt_a <= pe_cnt_a + int'(pe_a);
        ov_cnt_a <= ov_cnt_a + int'(ov_a);
        fe_cnt_b <= fe_cnt_b + int'(fe_b) + int'(ov_b);
        pe_cnt_b <= pe_cnt_b + int'(pe_b);
        vcyc_b   <= vcyc_b + int'(m_valid_b);
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // par < 0 means no parity bit; glitch_pos is the frame bit position
    // (0 = start) whose middle sample is inverted for one cycle, -1 for none.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int par, input logic stop_val, input int glitch_pos);
        logic bits [12];
        int   n;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nbits; i++) begin
            bits[n] = data[i]; n++;
        end
        if (par >= 0) begin
            bits[n] = par[0]; n++;
        end
        bits[n] = stop_val; n++;
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < BIT_CYC; c++) begin
                set_line(sel, (p == glitch_pos && c == 9) ? ~bits[p] : bits[p]);
                step(1);
            end
        end
        set_line(sel, 1'b1);
        step(BIT_CYC);
        $display("sent line%0d data 0x%03h", sel, data);
    endtask

    task automatic wait_a(input int target);
        for (int i = 0; i < 300; i++) begin
            if (got_n_a >= target) break;
            step(1);
        end
        step(4);
        @(negedge clk);
    endtask

    task automatic wait_b(input int target);
        for (int i = 0; i < 300; i++) begin
            if (got_n_b >= target) break;
            step(1);
        end
        step(4);
        @(negedge clk);
    endtask

    initial begin
        int ba, bfe, bpe, bov, bb, bfeb, bpeb, bvb;

        step(5);
        @(negedge clk);
        check("rst_hold_valid_a", 32'(m_valid_a), 32'h0);
        rst = 1'b0;
        step(2);
        @(negedge clk);
        check("rst_valid_a", 32'(m_valid_a), 32'h0);
        check("rst_data_a", 32'(m_data_a), 32'h0);
        check("rst_fe_a", 32'(fe_a), 32'h0);
        check("rst_pe_a", 32'(pe_a), 32'h0);
        check("rst_ov_a", 32'(ov_a), 32'h0);
        check("rst_valid_b", 32'(m_valid_b), 32'h0);

        // 8N1 stream of two bytes
        m_ready_a = 1'b1;
        ba = got_n_a; bfe = fe_cnt_a; bpe = pe_cnt_a; bov = ov_cnt_a;
        send_frame(0, 9'h0A5, 8, -1, 1'b1, -1);
        send_frame(0, 9'h03C, 8, -1, 1'b1, -1);
        wait_a(ba + 2);
        check("8n1_count", 32'(got_n_a - ba), 32'd2);
        check("8n1_byte0", 32'(got_a[6'(ba)]), 32'hA5);
        check("8n1_byte1", 32'(got_a[6'(ba + 1)]), 32'h3C);
        check("8n1_fe", 32'(fe_cnt_a - bfe), 32'd0);
        check("8n1_pe", 32'(pe_cnt_a - bpe), 32'd0);
        check("8n1_ov", 32'(ov_cnt_a - bov), 32'd0);

        // 7E1: 0x41 has even weight, so the correct parity bit is 0
        m_ready_b = 1'b1;
        bb = got_n_b; bfeb = fe_cnt_b; bpeb = pe_cnt_b; bvb = vcyc_b;
        send_frame(1, 9'h041, 7, 1, 1'b1, -1);
        step(20);
        @(negedge clk);
        check("par_err_pulses", 32'(pe_cnt_b - bpeb), 32'd1);
        check("par_valid_cycles", 32'(vcyc_b - bvb), 32'd0);
        check("par_fe_or_ov", 32'(fe_cnt_b - bfeb), 32'd0);
        send_frame(1, 9'h041, 7, 0, 1'b1, -1);
        wait_b(bb + 1);
        check("par_good_count", 32'(got_n_b - bb), 32'd1);
        check("par_good_byte", 32'(got_b[4'(bb)]), 32'h41);
        check("par_no_new_err", 32'(pe_cnt_b - bpeb), 32'd1);

        // Frame error then recovery
        ba = got_n_a; bfe = fe_cnt_a; bpe = pe_cnt_a;
        send_frame(0, 9'h055, 8, -1, 1'b0, -1);
        step(20);
        @(negedge clk);
        check("ferr_pulses", 32'(fe_cnt_a - bfe), 32'd1);
        check("ferr_nothing_pushed", 32'(got_n_a - ba), 32'd0);
        send_frame(0, 9'h012, 8, -1, 1'b1, -1);
        wait_a(ba + 1);
        check("ferr_next_count", 32'(got_n_a - ba), 32'd1);
        check("ferr_next_byte", 32'(got_a[6'(ba)]), 32'h12);
        check("ferr_single_pulse", 32'(fe_cnt_a - bfe), 32'd1);
        check("ferr_no_pe", 32'(pe_cnt_a - bpe), 32'd0);

        // Overrun with the consumer stalled
        m_ready_a = 1'b0;
        ba = got_n_a; bov = ov_cnt_a;
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 9'(i), 8, -1, 1'b1, -1);
        end
        step(20);
        @(negedge clk);
        check("ovr_pulses", 32'(ov_cnt_a - bov), 32'd1);
        check("ovr_valid", 32'(m_valid_a), 32'h1);
        check("ovr_head", 32'(m_data_a), 32'h01);
        check("ovr_no_pop", 32'(got_n_a - ba), 32'd0);
        step(1);
        m_ready_a = 1'b1;
        wait_a(ba + 4);
        check("drain_count", 32'(got_n_a - ba), 32'd4);
        check("drain_0", 32'(got_a[6'(ba)]), 32'h01);
        check("drain_1", 32'(got_a[6'(ba + 1)]), 32'h02);
        check("drain_2", 32'(got_a[6'(ba + 2)]), 32'h03);
        check("drain_3", 32'(got_a[6'(ba + 3)]), 32'h04);
        check("drain_empty", 32'(m_valid_a), 32'h0);

        // One-cycle idle glitch, then one corrupted middle sample in data bit 4
        ba = got_n_a; bfe = fe_cnt_a;
        set_line(0, 1'b0);
        step(1);
        set_line(0, 1'b1);
        step(60);
        @(negedge clk);
        check("glitch_no_frame", 32'(got_n_a - ba), 32'd0);
        check("glitch_no_fe", 32'(fe_cnt_a - bfe), 32'd0);
        send_frame(0, 9'h0F0, 8, -1, 1'b1, 5);
        wait_a(ba + 1);
        check("vote_count", 32'(got_n_a - ba), 32'd1);
        check("vote_byte", 32'(got_a[6'(ba)]), 32'hF0);
        check("vote_no_fe", 32'(fe_cnt_a - bfe), 32'd0);

        // Reset mid-frame with two bytes queued
        m_ready_a = 1'b0;
        step(1);
        send_frame(0, 9'h011, 8, -1, 1'b1, -1);
        send_frame(0, 9'h022, 8, -1, 1'b1, -1);
        set_line(0, 1'b0);
        step(BIT_CYC);
        set_line(0, 1'b1);
        step(BIT_CYC + 8);
        @(negedge clk);
        check("pre_rst_valid", 32'(m_valid_a), 32'h1);
        check("pre_rst_head", 32'(m_data_a), 32'h11);
        step(1);
        rst  = 1'b1;
        rx_a = 1'b1;
        step(1);
        @(negedge clk);
        check("midrst_valid", 32'(m_valid_a), 32'h0);
        check("midrst_data", 32'(m_data_a), 32'h0);
        check("midrst_fe", 32'(fe_a), 32'h0);
        check("midrst_pe", 32'(pe_a), 32'h0);
        check("midrst_ov", 32'(ov_a), 32'h0);
        step(1);
        rst = 1'b0;
        step(40);
        @(negedge clk);
        check("postrst_empty", 32'(m_valid_a), 32'h0);
        step(1);
        m_ready_a = 1'b1;
        ba = got_n_a;
        send_frame(0, 9'h07E, 8, -1, 1'b1, -1);
        wait_a(ba + 1);
        check("postrst_count", 32'(got_n_a - ba), 32'd1);
        check("postrst_byte", 32'(got_a[6'(ba)]), 32'h7E);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
